// File: rtl/alu_scheduler.sv
// +--------------------------------------------------------------------------+
// | alu_scheduler: two-requester front end for one shared combinational ALU.  |
// | Define ALU_SCHED_RR_EN for round-robin arbitration (default: fixed prio). |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_negative,
  output logic        resp_overflow,
  output logic        resp_carry,
  output logic        resp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_carry
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic        id_q;
  logic        grant_id, xfer, sel_legal;
  logic [2:0]  sel_op;
  logic [31:0] sel_a, sel_b;

`ifdef ALU_SCHED_RR_EN
  logic        last_grant;
`endif

  always_comb begin
    grant_id   = req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_SCHED_RR_EN
      grant_id = ~last_grant;
`else
      grant_id = 1'b0;
`endif
    end
    // Grants are withheld during the reset cycle so nothing is consumed then.
    xfer       = (state == IDLE) && (req0_valid || req1_valid) && !reset;
    req0_ready = xfer && !grant_id;
    req1_ready = xfer && grant_id;
    sel_op     = grant_id ? req1_op : req0_op;
    sel_a      = grant_id ? req1_a  : req0_a;
    sel_b      = grant_id ? req1_b  : req0_b;
    sel_legal  = (sel_op[1:0] != 2'b11);

    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = sel_legal ? EXEC : RESP;
      EXEC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_q          <= 3'b000;
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      id_q          <= 1'b0;
      resp_result   <= 32'd0;
      resp_zero     <= 1'b0;
      resp_negative <= 1'b0;
      resp_overflow <= 1'b0;
      resp_carry    <= 1'b0;
      resp_err      <= 1'b0;
`ifdef ALU_SCHED_RR_EN
      last_grant    <= 1'b1;
`endif
    end else begin
      state <= state_next;
      if (xfer) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant_id;
`ifdef ALU_SCHED_RR_EN
        last_grant <= grant_id;
`endif
        // Illegal ops skip the ALU and answer with an error response.
        if (!sel_legal) begin
          resp_result   <= 32'd0;
          resp_zero     <= 1'b0;
          resp_negative <= 1'b0;
          resp_overflow <= 1'b0;
          resp_carry    <= 1'b0;
          resp_err      <= 1'b1;
        end
      end
      if (state == EXEC) begin
        resp_result   <= alu_out;
        resp_zero     <= (alu_out == 32'd0);
        resp_negative <= alu_out[31];
        resp_overflow <= alu_overflow;
        resp_carry    <= alu_carry;
        resp_err      <= 1'b0;
      end
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_id    = id_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_ctrl   = op_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler with a behavioural ALU and reference model.
`default_nettype none

module tb_alu_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic resp_valid, resp_ready, resp_id;
  logic [31:0] resp_result;
  logic resp_zero, resp_negative, resp_overflow, resp_carry, resp_err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_ctrl;
  logic alu_overflow, alu_carry;
  logic [36:0] got_resp;
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  logic model_last;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .resp_zero(resp_zero), .resp_negative(resp_negative), .resp_overflow(resp_overflow),
    .resp_carry(resp_carry), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_carry(alu_carry)
  );

  // Returns {overflow, carry, out}; carry on SUB means "no borrow".
  function automatic logic [33:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      3'b000: return {2'b00, a & b};
      3'b001: return {2'b00, a | b};
      3'b010: return {2'b00, a ^ b};
      3'b100: begin s = {1'b0, a} + {1'b0, b};
                return {(a[31] == b[31]) && (s[31] != a[31]), s[32], s[31:0]}; end
      3'b101: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                return {(a[31] != b[31]) && (s[31] != a[31]), s[32], s[31:0]}; end
      3'b110: return {2'b00, 31'd0, ($signed(a) < $signed(b))};
      default: return {2'b11, a ^ b ^ 32'hDEAD_BEEF};
    endcase
  endfunction

  // Expected {err, carry, overflow, negative, zero, result}.
  function automatic logic [36:0] expect_resp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] r;
    if (op == 3'b011 || op == 3'b111) return {5'b10000, 32'd0};
    r = alu_fn(op, a, b);
    return {1'b0, r[32], r[33], r[31], (r[31:0] == 32'd0), r[31:0]};
  endfunction

  always_comb {alu_overflow, alu_carry, alu_out} = alu_fn(alu_ctrl, alu_a, alu_b);
  assign got_resp = {resp_err, resp_carry, resp_overflow, resp_negative, resp_zero, resp_result};

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic set_req(input bit n, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!n) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else    begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
  endtask

  task automatic apply_reset();
    reset = 1'b1; idle_inputs(); resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  // Called at the negedge just after the transfer edge; returns edges elapsed.
  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!resp_valid && cyc < 12) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    reset = 1'b1; resp_ready = 1'b0;
    set_req(0, 3'b100, 32'h1234, 32'h5678); set_req(1, 3'b000, 32'h1, 32'h2);
    @(negedge clk); @(negedge clk);
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
    end
    checks++; if ({resp_valid, resp_id, got_resp} !== 39'd0) begin
      failures++;
      $display("FAIL reset_resp: got %h expected 0", {resp_valid, resp_id, got_resp});
    end
    checks++; if ({alu_ctrl, alu_a, alu_b} !== 67'd0) begin
      failures++;
      $display("FAIL reset_alu_regs: got %h expected 0", {alu_ctrl, alu_a, alu_b});
    end
    idle_inputs(); reset = 1'b0; model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_overflow();
    int cyc;
    set_req(0, 3'b100, 32'h7FFF_FFFF, 32'h1); #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    model_last = 1'b0;
    @(negedge clk); idle_inputs(); wait_resp(cyc);
    checks++; if (cyc !== 2) begin
      failures++;
      $display("FAIL add_latency: got %0d expected 2", cyc);
    end
    checks++; if ({resp_id, got_resp} !== {1'b0, 5'b00110, 32'h8000_0000}) begin
      failures++;
      $display("FAIL add_resp: got %h expected %h", {resp_id, got_resp}, {1'b0, 5'b00110, 32'h8000_0000});
    end
    resp_ready = 1'b1; @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_valid_drop: got %b expected 0", resp_valid);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_sub_backpressure();
    int cyc;
    set_req(1, 3'b101, 32'd5, 32'd5); #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL sub_ready: got %b expected 01", {req0_ready, req1_ready});
    end
    model_last = 1'b1;
    @(negedge clk); idle_inputs(); wait_resp(cyc);
    checks++; if (cyc !== 2) begin
      failures++;
      $display("FAIL sub_latency: got %0d expected 2", cyc);
    end
    req0_valid = 1'b1; req0_op = 3'b000; req0_a = 32'hF; req0_b = 32'h3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({resp_valid, resp_id, req0_ready, req1_ready, got_resp} !== {1'b1, 1'b1, 2'b00, 5'b01001, 32'd0}) begin
        failures++;
        $display("FAIL sub_hold[%0d]: got %h expected %h", i,
                 {resp_valid, resp_id, req0_ready, req1_ready, got_resp}, {1'b1, 1'b1, 2'b00, 5'b01001, 32'd0});
      end
      @(negedge clk);
    end
    idle_inputs(); resp_ready = 1'b1; @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL sub_valid_drop: got %b expected 0", resp_valid);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int cyc;
    for (int k = 0; k < 2; k++) begin
      set_req(k[0], k[0] ? 3'b111 : 3'b011, $urandom, $urandom); #1;
      checks++; if ({req0_ready, req1_ready} !== (k[0] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL illegal_ready[%0d]: got %b", k, {req0_ready, req1_ready});
      end
      model_last = k[0];
      @(negedge clk); idle_inputs(); wait_resp(cyc);
      checks++; if (cyc !== 1) begin
        failures++;
        $display("FAIL illegal_latency[%0d]: got %0d expected 1", k, cyc);
      end
      checks++; if ({resp_id, got_resp} !== {k[0], 5'b10000, 32'd0}) begin
        failures++;
        $display("FAIL illegal_resp[%0d]: got %h expected %h", k, {resp_id, got_resp}, {k[0], 5'b10000, 32'd0});
      end
      resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [3:0]  exp_ids;
    logic [36:0] exp_r;
    logic        g;
    int cyc, w, prev_cycle;
`ifdef ALU_SCHED_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    apply_reset();
    resp_ready = 1'b1;
    prev_cycle = 0;
    for (int n = 0; n < 2; n++) begin
      op[n] = 3'($urandom_range(0, 2)) | {$urandom_range(0, 1) == 1, 2'b00};
      a[n] = $urandom; b[n] = $urandom;
    end
    for (int k = 0; k < 4; k++) begin
      set_req(0, op[0], a[0], b[0]); set_req(1, op[1], a[1], b[1]); #1;
      w = 0;
      while (!(req0_ready || req1_ready) && w < 12) begin @(negedge clk); #1; w++; end
      g = req1_ready;
      checks++; if ({req0_ready, req1_ready} !== (exp_ids[k] ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL b2b_grant[%0d]: got %b expected id %0d", k, {req0_ready, req1_ready}, exp_ids[k]);
      end
      if (k > 0) begin
        checks++; if (cycle - prev_cycle !== 3) begin
          failures++;
          $display("FAIL b2b_interval[%0d]: got %0d expected 3", k, cycle - prev_cycle);
        end
      end
      prev_cycle = cycle;
      exp_r = expect_resp(op[g], a[g], b[g]);
      model_last = g;
      @(negedge clk);
      op[g] = 3'($urandom_range(0, 2)) | {$urandom_range(0, 1) == 1, 2'b00};
      a[g] = $urandom; b[g] = $urandom;
      set_req(0, op[0], a[0], b[0]); set_req(1, op[1], a[1], b[1]);
      wait_resp(cyc);
      checks++; if ({resp_id, got_resp} !== {g, exp_r} || cyc !== 2) begin
        failures++;
        $display("FAIL b2b_resp[%0d]: got %h after %0d expected %h after 2", k, {resp_id, got_resp}, cyc, {g, exp_r});
      end
      @(negedge clk);
    end
    idle_inputs(); resp_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  op [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [36:0] exp_r;
    logic        g;
    int mode, cyc, d;
    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 2);
      for (int n = 0; n < 2; n++) begin
        op[n] = 3'($urandom_range(0, 7));
        a[n] = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        b[n] = ($urandom_range(0, 3) == 0) ? a[n] : $urandom;
      end
      if (mode != 1) set_req(0, op[0], a[0], b[0]);
      if (mode != 0) set_req(1, op[1], a[1], b[1]);
      #1;
`ifdef ALU_SCHED_RR_EN
      g = (mode == 2) ? ~model_last : mode[0];
`else
      g = (mode == 2) ? 1'b0 : mode[0];
`endif
      checks++; if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rand_grant[%0d]: got %b expected id %0d", k, {req0_ready, req1_ready}, g);
      end
      model_last = g;
      exp_r = expect_resp(op[g], a[g], b[g]);
      @(negedge clk); idle_inputs(); wait_resp(cyc);
      checks++; if (cyc !== (exp_r[36] ? 1 : 2)) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, cyc, exp_r[36] ? 1 : 2);
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      checks++; if ({resp_valid, resp_id, got_resp} !== {1'b1, g, exp_r}) begin
        failures++;
        $display("FAIL rand_resp[%0d]: got %h expected %h", k, {resp_valid, resp_id, got_resp}, {1'b1, g, exp_r});
      end
      resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    end
  endtask

  task automatic test_slt_reset();
    int cyc;
    set_req(0, 3'b110, 32'hFFFF_FFFF, 32'd1); #1;
    checks++; if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL slt_ready: got %b expected 1", req0_ready);
    end
    @(negedge clk); idle_inputs(); wait_resp(cyc);
    checks++; if ({cyc == 2, got_resp} !== {1'b1, 5'b00000, 32'd1}) begin
      failures++;
      $display("FAIL slt_resp: got %h after %0d expected 1 after 2", got_resp, cyc);
    end
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    set_req(1, 3'b100, $urandom, $urandom);
    @(negedge clk); idle_inputs();
    reset = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if ({resp_valid, req0_ready, req1_ready} !== 3'b000) begin
      failures++;
      $display("FAIL exec_reset_ready: got %b expected 000", {resp_valid, req0_ready, req1_ready});
    end
    reset = 1'b0; idle_inputs(); model_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({resp_valid, resp_id, got_resp} !== 39'd0) begin
        failures++;
        $display("FAIL exec_reset_noresp[%0d]: got %h expected 0", i, {resp_valid, resp_id, got_resp});
      end
      @(negedge clk);
    end
    set_req(0, 3'b000, 32'hF0, 32'hFF); #1;
    checks++; if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_idle: got %b expected 1", req0_ready);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; resp_ready = 1'b0; idle_inputs();
    req0_op = 3'b000; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 3'b000; req1_a = 32'd0; req1_b = 32'd0;
    model_last = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_slt_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
